catch_judge: RTL and testbench

- Downstream consumer of the datapath's ball outputs: ball colour, ball y position and the 15-frame step tick.
- Decides catch vs miss when the falling ball reaches the wheel rim; keeps BCD score and lives.
- Drives the datapath's feedback controls: new-colour enable, ball reset, speed-up request.
- Raises game-over for the top-level controller and the HEX displays.

---
 rtl/catch_judge.sv | 162 ++++++++++++++++
 tb/tb_catch_judge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/catch_judge.sv
`default_nettype none
// ============================================================================
// Module   : catch_judge
// Purpose  : Decides catch or miss when the falling ball reaches the wheel
//            rim, keeps a two-digit BCD score and the lives count, and drives
//            the ball datapath controls (new colour, ball reset, speed-up).
// Revision : 1.0 - initial release
// ============================================================================
module catch_judge #(
   parameter logic [6:0] CATCH_Y      = 7'd100,
   parameter logic [1:0] START_LIVES  = 2'd3,
   parameter logic [3:0] SPEEDUP_HITS = 4'd5
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       game_en,
   input  logic       step,
   input  logic [6:0] ball_y,
   input  logic [2:0] ball_colour,
   input  logic [2:0] wheel_colour,
   output logic [3:0] score_ones,
   output logic [3:0] score_tens,
   output logic [1:0] lives,
   output logic       hit,
   output logic       miss,
   output logic       new_col_en,
   output logic       reset_ball,
   output logic       incr_speed,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FALL    = 3'd1,
      JUDGE   = 3'd2,
      HIT     = 3'd3,
      MISS    = 3'd4,
      RESPAWN = 3'd5,
      OVER    = 3'd6
   } state_t;

   state_t     state;
   logic [2:0] ball_latch;
   logic [2:0] wheel_latch;
   logic [3:0] hit_cnt;

   // Game FSM: pulse outputs are registered together with the state they
   // belong to, so each one is high exactly while the FSM sits in that state.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         score_ones  <= 4'd0;
         score_tens  <= 4'd0;
         lives       <= 2'd0;
         hit_cnt     <= 4'd0;
         ball_latch  <= 3'd0;
         wheel_latch <= 3'd0;
         hit         <= 1'b0;
         miss        <= 1'b0;
         new_col_en  <= 1'b0;
         reset_ball  <= 1'b0;
         incr_speed  <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         hit        <= 1'b0;
         miss       <= 1'b0;
         new_col_en <= 1'b0;
         reset_ball <= 1'b0;
         incr_speed <= 1'b0;
         game_over  <= 1'b0;
         case (state)
            IDLE: begin
               // Score and lives are held here so the final score stays shown
               if (game_en) begin
                  score_ones <= 4'd0;
                  score_tens <= 4'd0;
                  lives      <= START_LIVES;
                  hit_cnt    <= 4'd0;
                  state      <= FALL;
               end
            end
            FALL: begin
               if (!game_en) begin
                  state <= IDLE;
               end else if (step && (ball_y >= CATCH_Y)) begin
                  // ">=" so a ball that jumps past the rim row is still judged
                  ball_latch  <= ball_colour;
                  wheel_latch <= wheel_colour;
                  state       <= JUDGE;
               end
            end
            JUDGE: begin
               if (!game_en) begin
                  state <= IDLE;
               end else if (ball_latch == wheel_latch) begin
                  hit   <= 1'b1;
                  state <= HIT;
               end else begin
                  miss  <= 1'b1;
                  state <= MISS;
               end
            end
            HIT: begin
               if (!game_en) begin
                  state <= IDLE;
               end else begin
                  // BCD increment saturating at 99
                  if (score_ones == 4'd9) begin
                     if (score_tens != 4'd9) begin
                        score_ones <= 4'd0;
                        score_tens <= score_tens + 4'd1;
                     end
                  end else begin
                     score_ones <= score_ones + 4'd1;
                  end
                  if (hit_cnt == SPEEDUP_HITS - 4'd1) begin
                     hit_cnt    <= 4'd0;
                     incr_speed <= 1'b1;
                  end else begin
                     hit_cnt <= hit_cnt + 4'd1;
                  end
                  reset_ball <= 1'b1;
                  new_col_en <= 1'b1;
                  state      <= RESPAWN;
               end
            end
            MISS: begin
               if (!game_en) begin
                  state <= IDLE;
               end else begin
                  // The hit counter deliberately survives a miss
                  lives <= lives - 2'd1;
                  if (lives == 2'd1) begin
                     game_over <= 1'b1;
                     state     <= OVER;
                  end else begin
                     reset_ball <= 1'b1;
                     new_col_en <= 1'b1;
                     state      <= RESPAWN;
                  end
               end
            end
            RESPAWN: begin
               state <= game_en ? FALL : IDLE;
            end
            OVER: begin
               // Restart needs game_en to go low first
               if (!game_en) begin
                  state <= IDLE;
               end else begin
                  game_over <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_catch_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_catch_judge
// Purpose  : Directed self-checking bench for catch_judge with a small score,
//            lives and hit-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_catch_judge;

   logic       clock = 1'b0;
   logic       resetn;
   logic       game_en;
   logic       step;
   logic [6:0] ball_y;
   logic [2:0] ball_colour;
   logic [2:0] wheel_colour;
   logic [3:0] score_ones;
   logic [3:0] score_tens;
   logic [1:0] lives;
   logic       hit;
   logic       miss;
   logic       new_col_en;
   logic       reset_ball;
   logic       incr_speed;
   logic       game_over;

   int vectors     = 0;
   int miscompares = 0;

   // Model state
   int m_score = 0;
   int m_lives = 0;
   int m_hits  = 0;

   catch_judge dut (
      .clock        (clock),
      .resetn       (resetn),
      .game_en      (game_en),
      .step         (step),
      .ball_y       (ball_y),
      .ball_colour  (ball_colour),
      .wheel_colour (wheel_colour),
      .score_ones   (score_ones),
      .score_tens   (score_tens),
      .lives        (lives),
      .hit          (hit),
      .miss         (miss),
      .new_col_en   (new_col_en),
      .reset_ball   (reset_ball),
      .incr_speed   (incr_speed),
      .game_over    (game_over)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] bcd(input int v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   // Order: reset_ball, new_col_en, incr_speed, game_over
   function automatic logic [3:0] ctl();
      return {reset_ball, new_col_en, incr_speed, game_over};
   endfunction

   // One full decision: step at the rim, then walk JUDGE, HIT/MISS, RESPAWN.
   task automatic run_catch(input string tag, input logic [2:0] bc, input logic [2:0] wc,
                            input logic [6:0] y, input bit respawn_step);
      bit match;
      bit over;
      bit exp_incr;
      match    = (bc == wc);
      over     = 1'b0;
      exp_incr = 1'b0;
      step = 1'b1; ball_y = y; ball_colour = bc; wheel_colour = wc;
      tick;
      step = 1'b0;
      ball_colour = 3'b111; wheel_colour = 3'b000;   // latched values must be used
      check($sformatf("%s_judge", tag), {30'd0, hit, miss}, 32'd0);
      tick;
      check($sformatf("%s_hitmiss", tag), {30'd0, hit, miss}, match ? 32'd2 : 32'd1);
      if (match) begin
         m_hits++;
         if (m_score < 99) m_score++;
         exp_incr = (m_hits % 5 == 0);
      end else begin
         m_lives--;
         over = (m_lives == 0);
      end
      tick;
      check($sformatf("%s_score", tag), {24'd0, score_tens, score_ones}, {24'd0, bcd(m_score)});
      check($sformatf("%s_lives", tag), {30'd0, lives}, 32'(m_lives));
      if (over)
         check($sformatf("%s_ctl_over", tag), {28'd0, ctl()}, 32'h1);
      else
         check($sformatf("%s_ctl", tag), {28'd0, ctl()}, {28'd0, 2'b11, exp_incr, 1'b0});
      if (respawn_step) begin
         step = 1'b1; ball_y = 7'd100; ball_colour = 3'b001; wheel_colour = 3'b001;
         tick;
         step = 1'b0;
         for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_rsp_ign%0d", tag, i), {30'd0, hit, miss}, 32'd0);
            tick;
         end
      end else begin
         tick;
         check($sformatf("%s_quiet", tag), {27'd0, hit, miss, reset_ball, new_col_en, incr_speed},
               32'd0);
         check($sformatf("%s_gover", tag), {31'd0, game_over}, {31'd0, over});
      end
   endtask

   initial begin
      resetn = 1'b0; game_en = 1'b1; step = 1'b0;
      ball_y = 7'd0; ball_colour = 3'd0; wheel_colour = 3'd0;

      // 1. Reset dominates game_en
      tick; tick;
      check("rst_outs", {22'd0, score_tens, score_ones, lives, hit, miss, ctl()}, 32'd0);
      resetn = 1'b1;
      tick;
      check("start_lives", {30'd0, lives}, 32'd3);
      check("start_score", {24'd0, score_tens, score_ones}, 32'd0);
      m_lives = 3; m_score = 0; m_hits = 0;

      // 2. Single catch with full latency checks
      run_catch("hit1", 3'b001, 3'b001, 7'd100, 1'b0);

      // 3. Three misses to game over
      run_catch("miss1", 3'b100, 3'b010, 7'd100, 1'b0);
      run_catch("miss2", 3'b100, 3'b010, 7'd100, 1'b0);
      run_catch("miss3", 3'b100, 3'b010, 7'd100, 1'b0);
      step = 1'b1; ball_y = 7'd100; ball_colour = 3'b001; wheel_colour = 3'b001;
      tick;
      step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check($sformatf("over_ign%0d", i), {28'd0, hit, miss, lives}, 32'd0);
         check($sformatf("over_lvl%0d", i), {31'd0, game_over}, 32'd1);
      end
      game_en = 1'b0;
      tick;
      check("idle_gover", {31'd0, game_over}, 32'd0);
      check("idle_score_held", {24'd0, score_tens, score_ones}, 32'h01);
      game_en = 1'b1;
      tick;
      check("restart_lives", {30'd0, lives}, 32'd3);
      check("restart_score", {24'd0, score_tens, score_ones}, 32'd0);
      m_lives = 3; m_score = 0; m_hits = 0;

      // 4. BCD carry, saturation at 99, speed-up every fifth hit
      for (int i = 0; i < 9; i++) run_catch("bulk_a", 3'b010, 3'b010, 7'd100, 1'b0);
      check("score_09", {24'd0, score_tens, score_ones}, 32'h09);
      run_catch("carry", 3'b000, 3'b000, 7'd100, 1'b0);
      check("score_10", {24'd0, score_tens, score_ones}, 32'h10);
      for (int i = 0; i < 89; i++) run_catch("bulk_b", 3'b110, 3'b110, 7'd100, 1'b0);
      check("score_99", {24'd0, score_tens, score_ones}, 32'h99);
      run_catch("sat", 3'b011, 3'b011, 7'd100, 1'b0);
      check("score_sat", {24'd0, score_tens, score_ones}, 32'h99);
      run_catch("zero_miss", 3'b000, 3'b001, 7'd100, 1'b0);

      // 5. Row threshold and step during RESPAWN
      step = 1'b1; ball_y = 7'd99; ball_colour = 3'b001; wheel_colour = 3'b001;
      tick;
      step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check($sformatf("y99_nodec%0d", i), {30'd0, hit, miss}, 32'd0);
      end
      run_catch("y102", 3'b101, 3'b101, 7'd102, 1'b0);
      run_catch("rsp_step", 3'b001, 3'b001, 7'd100, 1'b1);

      // 6. game_en dropped in the HIT cycle
      step = 1'b1; ball_y = 7'd100; ball_colour = 3'b010; wheel_colour = 3'b010;
      tick;
      step = 1'b0;
      tick;
      check("drop_hit", {31'd0, hit}, 32'd1);
      game_en = 1'b0;
      tick;
      check("drop_ctl", {28'd0, ctl()}, 32'd0);
      check("drop_score", {24'd0, score_tens, score_ones}, 32'h99);
      tick;
      check("drop_idle_quiet", {26'd0, hit, miss, ctl()}, 32'd0);
      game_en = 1'b1;
      tick;
      m_lives = 3; m_score = 0; m_hits = 0;
      check("drop_restart", {24'd0, score_tens, score_ones}, 32'd0);

      // Reset asserted mid-operation while control pulses are high
      step = 1'b1; ball_y = 7'd100; ball_colour = 3'b100; wheel_colour = 3'b100;
      tick;
      step = 1'b0;
      tick; tick;
      check("pre_rst_ctl", {28'd0, ctl()}, 32'hC);
      resetn = 1'b0;
      tick;
      check("mid_rst_outs", {22'd0, score_tens, score_ones, lives, hit, miss, ctl()}, 32'd0);
      resetn = 1'b1;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
